// File: rtl/convolve_fpga_div_16s_8ns_16_seq.sv
// -----------------------------------------------------------------------------
// convolve_fpga_div_16s_8ns_16_seq
//
// Purpose:
//   Iterative radix-2 divider for the convolution datapath. It divides a 16-bit
//   signed dividend (the accumulated, weighted pixel sum) by an 8-bit unsigned
//   divisor (the kernel normalisation factor). It produces one quotient bit per
//   enabled clock. The latency is fixed at 16 enabled cycles from accept to
//   out_valid, and this holds for a divisor of zero as well.
//   Results truncate toward zero. The quotient and the remainder both take the
//   sign of the dividend, and |rem| < divisor.
//   Dividing by zero saturates the quotient to 16'h7FFF (dividend >= 0) or
//   16'h8000 (dividend < 0), forces rem to 0 and flags div_by_zero.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset (overrides ce)
//   ce           clock enable; low freezes every register
//   in_valid     operands valid           in_ready     high only while idle
//   din0 [15:0]  signed dividend          din1 [7:0]   unsigned divisor
//   out_valid    result valid (DONE)      out_ready    consumer takes result
//   dout [15:0]  signed quotient          rem  [8:0]   signed remainder
//   div_by_zero  result came from a zero divisor
// -----------------------------------------------------------------------------
module convolve_fpga_div_16s_8ns_16_seq #(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd16,
    parameter int unsigned din1_WIDTH = 32'd8,
    parameter int unsigned dout_WIDTH = 32'd16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [8:0]            rem,
    output logic                  div_by_zero
);

    // The datapath is hand-sized for 16s / 8u. Reject any other configuration
    // at elaboration time so that no netlist is silently mis-sized.
    generate
        if (din0_WIDTH != 32'd16 || din1_WIDTH != 32'd8 || dout_WIDTH != 32'd16) begin : g_width_guard
            $error("convolve_fpga_div_16s_8ns_16_seq instance %0d: only 16s/8u/16 widths are supported", ID);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Operand and iteration registers
    logic [16:0] r_mag;        // |dividend|; needs 17 bits so that -32768 can be represented
    logic [7:0]  r_divisor;
    logic        r_neg;        // dividend sign, which both results inherit
    logic        r_zero;       // divisor was zero
    logic [7:0]  r_prem;       // partial remainder, always < divisor for a nonzero divisor
    logic [15:0] r_quot;       // quotient magnitude, built MSB first
    logic [3:0]  r_cnt;        // dividend bit consumed this cycle (15 down to 0)

    // Registered results
    logic [15:0] r_dout;
    logic [8:0]  r_rem;
    logic        r_dbz;

    // Combinational helpers
    logic        w_accept;
    logic        w_last;
    logic [16:0] w_abs;
    logic [8:0]  w_trial;
    logic        w_fits;
    logic [8:0]  w_diff;
    logic [7:0]  w_prem_next;
    logic [15:0] w_quot_next;
    logic [15:0] w_q_signed;
    logic [8:0]  w_r_signed;

    assign w_accept = in_valid & ce & (r_state == S_IDLE);
    assign w_last   = (r_cnt == 4'd0);

    // Sign-extend first and then negate, so that -32768 gives +32768.
    assign w_abs = din0[15] ? (17'd0 - {din0[15], din0}) : {1'b0, din0};

    // A single restoring step: shift in the next dividend bit, then subtract
    // the divisor when the shifted value is large enough.
    assign w_trial     = {r_prem, r_mag[r_cnt]};
    assign w_fits      = (w_trial >= {1'b0, r_divisor});
    assign w_diff      = w_trial - {1'b0, r_divisor};
    // For a nonzero divisor the trial value is below 2*divisor, so 8 bits hold
    // the new remainder. For a zero divisor the value is discarded anyway.
    assign w_prem_next = w_fits ? w_diff[7:0] : w_trial[7:0];
    assign w_quot_next = {r_quot[14:0], w_fits};

    // Sign fix-up on the final step. Negating 16'h8000 gives 16'h8000 again,
    // so -32768 / 1 comes out correct without any special case.
    assign w_q_signed = r_neg ? (16'd0 - w_quot_next) : w_quot_next;
    assign w_r_signed = r_neg ? (9'd0 - {1'b0, w_prem_next}) : {1'b0, w_prem_next};

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)            w_state_next = S_CALC;
            S_CALC: if (ce && w_last)        w_state_next = S_DONE;
            S_DONE: if (ce && out_ready)     w_state_next = S_IDLE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mag     <= '0;
            r_divisor <= '0;
            r_neg     <= 1'b0;
            r_zero    <= 1'b0;
            r_prem    <= '0;
            r_quot    <= '0;
            r_cnt     <= '0;
            r_dout    <= '0;
            r_rem     <= '0;
            r_dbz     <= 1'b0;
        end else if (ce) begin
            if (w_accept) begin
                r_mag     <= w_abs;
                r_divisor <= din1;
                r_neg     <= din0[15];
                r_zero    <= (din1 == 8'd0);
                r_prem    <= '0;
                r_quot    <= '0;
                r_cnt     <= 4'd15;
            end else if (r_state == S_CALC) begin
                r_prem <= w_prem_next;
                r_quot <= w_quot_next;
                r_cnt  <= r_cnt - 4'd1;
                if (w_last) begin
                    if (r_zero) begin
                        r_dout <= r_neg ? 16'h8000 : 16'h7FFF;
                        r_rem  <= '0;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_dout <= w_q_signed;
                        r_rem  <= w_r_signed;
                        r_dbz  <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign dout        = r_dout;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: doc/convolve_fpga_div_16s_8ns_16_seq.md
# convolve_fpga_div_16s_8ns_16_seq

Sequential signed-by-unsigned divider for the convolution datapath: divides a 16-bit signed dividend (accumulated, weighted pixel sum) by an 8-bit unsigned divisor (kernel normalisation factor) and returns a 16-bit signed quotient plus remainder. It is the inverse arithmetic stage to the pipelined 16s×8ns multiplier and sits after the accumulator, before output packing. It is radix-2, iterative, one quotient bit per enabled cycle, with valid/ready handshakes on both sides and a global clock-enable consistent with the other arithmetic cores.

## Interface
- ID, 32'd1, instance identifier, no functional effect
- din0_WIDTH, 32'd16, dividend width, fixed at 16
- din1_WIDTH, 32'd8, divisor width, fixed at 8
- dout_WIDTH, 32'd16, quotient width, fixed at 16

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- ce  in  1  clock enable; low freezes all state, outputs hold
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- din0  in  16  signed dividend
- din1  in  8  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  16  signed quotient
- rem  out  9  signed remainder
- div_by_zero  out  1  result came from divisor == 0

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready = 1. Accept when in_valid & in_ready & ce: latch |din0| (17-bit magnitude), din1, sign of din0, zero flag (din1 == 0); clear partial remainder; iteration counter = 15; → CALC.
- CALC: in_ready = 0. Each ce cycle: shift partial remainder left by one bit, bringing in the next dividend MSB; if the result is ≥ divisor, subtract and set the quotient bit. Counter decrements. On the counter == 0 cycle, apply the sign fix-up and register dout/rem/div_by_zero → DONE.
- Arithmetic: truncation toward zero. Quotient sign = dividend sign. Remainder sign = dividend sign, |rem| < divisor. -32768/1 = -32768, rem 0. There is no overflow except divide-by-zero.
- Divide-by-zero: CALC still runs all 16 cycles, so latency stays fixed. Final result forced to dout = 16'h7FFF if dividend ≥ 0, 16'h8000 if negative; rem = 0; div_by_zero = 1.
- DONE: out_valid = 1; dout/rem/div_by_zero stable. When out_ready & ce → IDLE, out_valid drops the next cycle.
- in_ready is asserted only in IDLE. There is no overlap of consecutive operations.
- Reset values: in_ready = 1, out_valid = 0, dout = 0, rem = 0, div_by_zero = 0, state IDLE.

## Timing
- Accept at edge T. CALC occupies edges T+1..T+16. out_valid is high after edge T+16, so latency is 16 enabled cycles.
- Minimum initiation interval: 18 cycles (accept, 16 CALC, DONE handshake, return to IDLE).
- ce low: no state, counter, or output change, including mid-CALC and in DONE. Latency counts enabled cycles only.
- out_ready low in DONE: hold the result indefinitely, in_ready stays 0.
- in_valid while not in IDLE is ignored. Operands are sampled only on the accept edge.
- reset_n low on any edge, in any state: next cycle state IDLE and all outputs at reset values. The in-flight operation is discarded with no out_valid pulse.
- reset_n overrides ce.

## Test plan
- 100 / 7, ce = 1, out_ready = 1 → out_valid 16 cycles after accept, dout = 14, rem = 2, div_by_zero = 0.
- -100 / 7 then 32767 / 255 → dout = -14, rem = -2; then dout = 128, rem = 127. in_ready is 0 throughout CALC/DONE.
- -32768 / 1 and -32768 / 255 → (-32768, 0) and (-128, -128). 5 / 0 → 16'h7FFF, div_by_zero = 1. -5 / 0 → 16'h8000, rem 0.
- 1000 / 3 with out_ready low 5 cycles in DONE, then ce low 3 cycles mid-CALC → result 333 rem 1 held stable. Completion is delayed exactly 3 cycles. Single out_valid handshake.
- reset_n low for 1 cycle at CALC cycle 8 → next cycle in_ready = 1, out_valid = 0. A fresh 50 / 5 completes with 10 rem 0.
- Random sweep of 10k operand pairs, including divisor 0 and extremes → compare against a reference model using truncate-toward-zero semantics.
